// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku board checker family.
// Optional error-location outputs are enabled by defining SUDOKU_ERR_LOC_EN.
package sudoku_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrIllegal = 2'd1;
  localparam logic [1:0] ErrRowCol  = 2'd2;
  localparam logic [1:0] ErrBox     = 2'd3;

  function automatic int unsigned board_n(input int unsigned box);
    return box * box;
  endfunction

endpackage

// File: rtl/digit_onehot.sv
// Combinational digit decoder: 1..N maps to a one-hot bit, 0 or >N flags illegal.
module digit_onehot #(
  parameter int unsigned N       = 4,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] digit,
  output logic [N-1:0]       onehot,
  output logic               illegal
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = (digit == DIGIT_W'(i + 1));
    end
    illegal = ~|onehot;
  end

endmodule

// File: rtl/sudoku_board_checker.sv
// Streams an N x N board row-major and issues one legality verdict per board.
// Define SUDOKU_ERR_LOC_EN to expose the location and kind of the first failing cell.
module sudoku_board_checker
  import sudoku_pkg::*;
#(
  parameter int unsigned BOX     = 2,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cell_valid,
  input  logic [DIGIT_W-1:0] cell_digit,
  output logic               cell_ready,
  output logic               result_valid,
  output logic               board_correct,
  output logic               busy
`ifdef SUDOKU_ERR_LOC_EN
  ,
  output logic [$clog2(BOX*BOX)-1:0] err_row,
  output logic [$clog2(BOX*BOX)-1:0] err_col,
  output logic [1:0]                 err_kind
`endif
);

  localparam int unsigned N    = board_n(BOX);
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned BoxW = (BOX > 1) ? $clog2(BOX) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [IdxW-1:0] BoxEdge = IdxW'(BOX);
  localparam logic [IdxW-1:0] BoxLast = IdxW'(BOX - 1);

  state_e state_q, state_d;
  logic [IdxW-1:0] row_q, row_d, col_q, col_d;
  logic            err_q, err_d;
  logic [N-1:0]    row_mask_q, row_mask_d;
  logic [N-1:0]    col_mask_q [N];
  logic [N-1:0]    col_mask_d [N];
  logic [N-1:0]    box_mask_q [BOX];
  logic [N-1:0]    box_mask_d [BOX];

  logic [N-1:0]    onehot;
  logic            illegal;
  logic [BoxW-1:0] box_col;
  logic            xfer, last_cell, row_box_end;
  logic            row_hit, col_hit, box_hit, new_err;

  digit_onehot #(
    .N       (N),
    .DIGIT_W (DIGIT_W)
  ) u_dec (
    .digit   (cell_digit),
    .onehot  (onehot),
    .illegal (illegal)
  );

  // start wins over a coincident transfer, which is dropped
  assign xfer        = (state_q == StRun) & cell_valid & ~start;
  assign last_cell   = (row_q == LastIdx) & (col_q == LastIdx);
  assign box_col     = BoxW'(col_q / BoxEdge);
  assign row_box_end = ((row_q % BoxEdge) == BoxLast);
  assign row_hit     = |(onehot & row_mask_q);
  assign col_hit     = |(onehot & col_mask_q[col_q]);
  assign box_hit     = |(onehot & box_mask_q[box_col]);
  assign new_err     = illegal | row_hit | col_hit | box_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (xfer && last_cell) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cell_ready    = (state_q == StRun);
    busy          = (state_q == StRun);
    result_valid  = (state_q == StDone);
    board_correct = (state_q == StDone) & ~err_q;
  end

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    err_d      = err_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    box_mask_d = box_mask_q;
    if (start) begin
      row_d      = '0;
      col_d      = '0;
      err_d      = 1'b0;
      row_mask_d = '0;
      col_mask_d = '{default: '0};
      box_mask_d = '{default: '0};
    end else if (xfer) begin
      err_d      = err_q | new_err;
      row_mask_d = row_mask_q | onehot;
      for (int unsigned i = 0; i < N; i++) begin
        if (col_q == IdxW'(i)) col_mask_d[i] = col_mask_q[i] | onehot;
      end
      for (int unsigned i = 0; i < BOX; i++) begin
        if (box_col == BoxW'(i)) box_mask_d[i] = box_mask_q[i] | onehot;
      end
      if (col_q == LastIdx) begin
        col_d      = '0;
        row_d      = row_q + IdxW'(1);
        row_mask_d = '0;
        if (row_box_end) box_mask_d = '{default: '0};
      end else begin
        col_d = col_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
      row_mask_q <= '0;
      col_mask_q <= '{default: '0};
      box_mask_q <= '{default: '0};
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      err_q      <= err_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      box_mask_q <= box_mask_d;
    end
  end

`ifdef SUDOKU_ERR_LOC_EN
  logic [IdxW-1:0] err_row_q, err_col_q;
  logic [1:0]      err_kind_q;

  // only the first failing cell of a board is recorded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_row_q  <= '0;
      err_col_q  <= '0;
      err_kind_q <= ErrNone;
    end else if (start) begin
      err_row_q  <= '0;
      err_col_q  <= '0;
      err_kind_q <= ErrNone;
    end else if (xfer && !err_q && new_err) begin
      err_row_q  <= row_q;
      err_col_q  <= col_q;
      err_kind_q <= illegal            ? ErrIllegal :
                    (row_hit | col_hit) ? ErrRowCol  : ErrBox;
    end
  end

  assign err_row  = err_row_q;
  assign err_col  = err_col_q;
  assign err_kind = err_kind_q;
`endif

endmodule

// File: tb/tb_sudoku_board_checker.sv
// Directed bench for the 4x4 and 9x9 board checker; error-location checks
// are included when SUDOKU_ERR_LOC_EN is defined.
module tb_sudoku_board_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start2 = 1'b0, valid2 = 1'b0, start3 = 1'b0, valid3 = 1'b0;
  logic [3:0] digit2 = 4'h0, digit3 = 4'h0;
  logic       ready2, rv2, ok2, busy2;
  logic       ready3, rv3, ok3, busy3;
`ifdef SUDOKU_ERR_LOC_EN
  logic [1:0] er2, ec2, ek2, ek3;
  logic [3:0] er3, ec3;
`endif

  int vectors = 0;
  int fails = 0;

  localparam logic [63:0]  B_OK    = 64'h1234_3412_2143_4321;
  localparam logic [63:0]  B_DUP   = 64'h1234_3412_2134_4321;
  localparam logic [63:0]  B_EMPTY = 64'h1204_3412_2143_4321;
  localparam logic [323:0] B9_OK   = 324'h123456789_456789123_789123456_234567891_567891234_891234567_345678912_678912345_912345678;
  localparam logic [323:0] B9_LAT  = 324'h123456789_234567891_345678912_456789123_567891234_678912345_789123456_891234567_912345678;

  always #5 clk = ~clk;

  sudoku_board_checker #(.BOX(2), .DIGIT_W(4)) dut2 (
    .clk (clk), .rst_n (rst_n), .start (start2), .cell_valid (valid2), .cell_digit (digit2),
    .cell_ready (ready2), .result_valid (rv2), .board_correct (ok2), .busy (busy2)
`ifdef SUDOKU_ERR_LOC_EN
    , .err_row (er2), .err_col (ec2), .err_kind (ek2)
`endif
  );

  sudoku_board_checker #(.BOX(3), .DIGIT_W(4)) dut3 (
    .clk (clk), .rst_n (rst_n), .start (start3), .cell_valid (valid3), .cell_digit (digit3),
    .cell_ready (ready3), .result_valid (rv3), .board_correct (ok3), .busy (busy3)
`ifdef SUDOKU_ERR_LOC_EN
    , .err_row (er3), .err_col (ec3), .err_kind (ek3)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit big, input logic s, input logic v, input logic [3:0] d);
    if (big) begin
      start3 = s; valid3 = v; digit3 = d;
    end else begin
      start2 = s; valid2 = v; digit2 = d;
    end
  endtask

  function automatic logic rv_of(input bit big);
    return big ? rv3 : rv2;
  endfunction

  function automatic logic ok_of(input bit big);
    return big ? ok3 : ok2;
  endfunction

  function automatic logic busy_of(input bit big);
    return big ? busy3 : busy2;
  endfunction

  // Start carries a valid cell too; if it were not discarded the board would miscount.
  task automatic run_board(input bit big, input logic [323:0] b, input bit gaps,
                           input logic exp_ok, input string tag);
    int n = big ? 81 : 16;
    drive(big, 1'b1, 1'b1, 4'h1);
    tick;
    chk({tag, " busy"}, 32'(busy_of(big)), 32'd1);
    chk({tag, " rv_cleared"}, 32'(rv_of(big)), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        drive(big, 1'b0, 1'b0, 4'h0);
        tick;
      end
      drive(big, 1'b0, 1'b1, b[(n-1-i)*4 +: 4]);
      if (i == n - 1) chk({tag, " rv_before_last"}, 32'(rv_of(big)), 32'd0);
      tick;
    end
    drive(big, 1'b0, 1'b0, 4'h0);
    chk({tag, " rv"}, 32'(rv_of(big)), 32'd1);
    chk({tag, " correct"}, 32'(ok_of(big)), 32'(exp_ok));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    chk("reset rv2", 32'(rv2), 32'd0);
    chk("reset ok2", 32'(ok2), 32'd0);
    chk("reset busy2", 32'(busy2), 32'd0);
    chk("reset ready2", 32'(ready2), 32'd0);
    chk("reset rv3", 32'(rv3), 32'd0);
    chk("reset busy3", 32'(busy3), 32'd0);
`ifdef SUDOKU_ERR_LOC_EN
    chk("reset kind2", 32'(ek2), 32'd0);
`endif
    rst_n = 1'b1;
    tick;
    drive(1'b0, 1'b0, 1'b1, 4'h1);
    tick;
    chk("idle ignores valid", 32'(ready2), 32'd0);

    run_board(1'b0, 324'(B_OK), 1'b0, 1'b1, "b2_ok");

    drive(1'b0, 1'b0, 1'b1, 4'h1);
    tick;
    tick;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    chk("done hold rv", 32'(rv2), 32'd1);
    chk("done hold ok", 32'(ok2), 32'd1);

    run_board(1'b0, 324'(B_DUP), 1'b0, 1'b0, "b2_dup");
`ifdef SUDOKU_ERR_LOC_EN
    chk("dup row", 32'(er2), 32'd2);
    chk("dup col", 32'(ec2), 32'd2);
    chk("dup kind", 32'(ek2), 32'd2);
`endif

    run_board(1'b0, 324'(B_EMPTY), 1'b0, 1'b0, "b2_empty");
`ifdef SUDOKU_ERR_LOC_EN
    chk("empty row", 32'(er2), 32'd0);
    chk("empty col", 32'(ec2), 32'd2);
    chk("empty kind", 32'(ek2), 32'd1);
`endif

    run_board(1'b0, 324'(B_OK), 1'b1, 1'b1, "b2_gaps");

    // abandon a bad partial board after 7 cells
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    tick;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'h1);
      tick;
    end
    run_board(1'b0, 324'(B_OK), 1'b0, 1'b1, "b2_restart");

    drive(1'b0, 1'b1, 1'b0, 4'h0);
    tick;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, B_OK[(15-i)*4 +: 4]);
      tick;
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy2), 32'd0);
    chk("midreset ready", 32'(ready2), 32'd0);
    chk("midreset rv", 32'(rv2), 32'd0);
    chk("midreset ok", 32'(ok2), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post reset idle", 32'(busy2), 32'd0);
    run_board(1'b0, 324'(B_OK), 1'b0, 1'b1, "b2_recover");

    run_board(1'b1, B9_OK, 1'b0, 1'b1, "b3_ok");
    run_board(1'b1, B9_LAT, 1'b0, 1'b0, "b3_box");
`ifdef SUDOKU_ERR_LOC_EN
    chk("box row", 32'(er3), 32'd1);
    chk("box col", 32'(ec3), 32'd0);
    chk("box kind", 32'(ek3), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
